seg_595_scan: RTL

//  Downstream consumer of the RAM read path: takes the 8-bit word read back from RAM and shows it in

---
 rtl/seg_595_scan.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_595_scan.sv
// -----------------------------------------------------------------------------
// seg_595_scan
//   Shows an 8-bit unsigned value (000..255) in decimal on a 6-digit
//   common-anode seven-segment display. The display is driven through a
//   74HC595 shift-register chain.
//   A sequential double-dabble converter turns the value into BCD. A scan
//   counter steps through the digits, one per dwell period. At each step a
//   14-bit {seg,sel} frame is shifted out LSB first and then latched.
//
// Parameters
//   CNT_SCAN_MAX : digit dwell time minus 1, in sys_clk cycles (must be >= 63)
//
// Ports
//   sys_clk   in   system clock
//   sys_rst_n in   asynchronous reset, active low
//   data      in   [7:0] value to display
//   seg_en    in   display enable (1 = on)
//   ds        out  595 serial data
//   shcp      out  595 shift clock
//   stcp      out  595 storage/latch clock
//   oe        out  595 output enable, active low
//
// Configuration macro
//   SEG_BLANK_EN : when defined, leading zeros on hundreds/tens are blanked.
// -----------------------------------------------------------------------------
module seg_595_scan #(
  parameter logic [15:0] CNT_SCAN_MAX = 16'd49_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] data,
  input  logic       seg_en,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe
);

  typedef enum logic {
    CONV_IDLE,
    CONV_RUN
  } conv_state_t;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_SHIFT,
    SH_LATCH
  } sh_state_t;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[11:8] >= 4'd5)   t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5)  t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5)  t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  // Active-low segment pattern {dp,g..a}; dp is always off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  conv_state_t conv_state_q, conv_state_d;
  logic [7:0]  last_data_q, last_data_d;
  logic [19:0] sr_q, sr_d;
  logic [3:0]  iter_q, iter_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        tick;

  sh_state_t   sh_state_q, sh_state_d;
  logic [13:0] frame_q, frame_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  phase_q, phase_d;
  logic        latch_q, latch_d;

  logic        ds_q, ds_d;
  logic        shcp_q, shcp_d;
  logic        stcp_q, stcp_d;
  logic        oe_q, oe_d;

  logic        blank_hund;
  logic        blank_tens;
  logic [7:0]  seg_cur;
  logic [5:0]  sel_cur;

  // ---------------------------------------------------------------------------
  // BCD converter. A new value is sampled only while idle. After the load
  // cycle come 8 dabble cycles and one commit cycle, so a value change shows
  // up in the digit registers 10 cycles later. Changes seen mid-conversion are
  // picked up on the next idle cycle, because last_data still differs.
  // ---------------------------------------------------------------------------
  always_comb begin
    conv_state_d = conv_state_q;
    last_data_d  = last_data_q;
    sr_d         = sr_q;
    iter_d       = iter_q;
    hund_d       = hund_q;
    tens_d       = tens_q;
    units_d      = units_q;
    case (conv_state_q)
      CONV_IDLE: begin
        if (data != last_data_q) begin
          last_data_d  = data;
          sr_d         = {12'd0, data};
          iter_d       = 4'd0;
          conv_state_d = CONV_RUN;
        end
      end
      CONV_RUN: begin
        if (iter_q == 4'd8) begin
          hund_d       = sr_q[19:16];
          tens_d       = sr_q[15:12];
          units_d      = sr_q[11:8];
          conv_state_d = CONV_IDLE;
        end else begin
          sr_d   = dabble_step(sr_q);
          iter_d = iter_q + 4'd1;
        end
      end
      default: conv_state_d = CONV_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan counter and digit index. The frame started by a tick uses the index
  // from before the tick, so the first frame after reset is digit 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    tick  = (cnt_q == CNT_SCAN_MAX);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Leading-zero blanking only matters when the macro is defined.
  always_comb begin
`ifdef SEG_BLANK_EN
    blank_hund = (hund_q == 4'd0);
    blank_tens = (hund_q == 4'd0) && (tens_q == 4'd0);
`else
    blank_hund = 1'b0;
    blank_tens = 1'b0;
`endif
  end

  // Segment pattern and one-hot select for the digit currently addressed.
  always_comb begin
    sel_cur = 6'b000001 << idx_q;
    case (idx_q)
      3'd0:    seg_cur = seg_code(units_q);
      3'd1:    seg_cur = blank_tens ? 8'hFF : seg_code(tens_q);
      3'd2:    seg_cur = blank_hund ? 8'hFF : seg_code(hund_q);
      default: seg_cur = 8'hFF;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift engine. Each bit occupies four phases, and shcp is high in phases 2
  // and 3. The output registers are computed from the next-state values. This
  // keeps ds/shcp/stcp aligned with the state registers while staying
  // registered.
  // ---------------------------------------------------------------------------
  always_comb begin
    sh_state_d = sh_state_q;
    frame_d    = frame_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    latch_d    = latch_q;
    case (sh_state_q)
      SH_IDLE: begin
        if (tick) begin
          frame_d    = {seg_cur, sel_cur};
          bit_d      = 4'd0;
          phase_d    = 2'd0;
          sh_state_d = SH_SHIFT;
        end
      end
      SH_SHIFT: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (bit_q == 4'd13) begin
            latch_d    = 1'b0;
            sh_state_d = SH_LATCH;
          end else begin
            bit_d   = bit_q + 4'd1;
            frame_d = {1'b0, frame_q[13:1]};
          end
        end
      end
      SH_LATCH: begin
        if (latch_q) begin
          sh_state_d = SH_IDLE;
        end else begin
          latch_d = 1'b1;
        end
      end
      default: sh_state_d = SH_IDLE;
    endcase

    ds_d   = (sh_state_d == SH_SHIFT) ? frame_d[0] : 1'b0;
    shcp_d = (sh_state_d == SH_SHIFT) && phase_d[1];
    stcp_d = (sh_state_d == SH_LATCH);
    oe_d   = ~seg_en;
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset aborts any frame in flight, so no latch pulse is issued.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      conv_state_q <= CONV_IDLE;
      last_data_q  <= 8'd0;
      sr_q         <= 20'd0;
      iter_q       <= 4'd0;
      hund_q       <= 4'd0;
      tens_q       <= 4'd0;
      units_q      <= 4'd0;
      cnt_q        <= 16'd0;
      idx_q        <= 3'd0;
      sh_state_q   <= SH_IDLE;
      frame_q      <= 14'd0;
      bit_q        <= 4'd0;
      phase_q      <= 2'd0;
      latch_q      <= 1'b0;
      ds_q         <= 1'b0;
      shcp_q       <= 1'b0;
      stcp_q       <= 1'b0;
      oe_q         <= 1'b1;
    end else begin
      conv_state_q <= conv_state_d;
      last_data_q  <= last_data_d;
      sr_q         <= sr_d;
      iter_q       <= iter_d;
      hund_q       <= hund_d;
      tens_q       <= tens_d;
      units_q      <= units_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_state_q   <= sh_state_d;
      frame_q      <= frame_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      latch_q      <= latch_d;
      ds_q         <= ds_d;
      shcp_q       <= shcp_d;
      stcp_q       <= stcp_d;
      oe_q         <= oe_d;
    end
  end

  assign ds   = ds_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  assign oe   = oe_q;

endmodule
